simon_pad_renderer: RTL
=======================

Name: simon_pad_renderer

Overview:
- Parametrised successor to the single-pad-set drawing FSM. Renders N_PADS square pads at table-configured screen coordinates and highlights one pad at a time.
- Highlight requests come from either the player (clicked + direction) or a sequence-playback source (valid/ready).
- Emits one plot command per pad update over a valid/ready handshake to the VGA square plotter.
- Sits between the input/sequence logic and the plotter.

Parameters:
- N_PADS, 4, number of pads (2..8).
- PAD_W, 2, pad index width; must be ≥ clog2(N_PADS).
- PAD_X_TABLE, {8'd74,8'd82,8'd78,8'd78}, packed 8-bit x per pad; pad 0 in the LSBs. Order: 0=up, 1=down, 2=right, 3=left.
- PAD_Y_TABLE, {7'd58,7'd58,7'd62,7'd54}, packed 7-bit y per pad, same order.
- IDLE_COLOR, 3'b111, unlit pad colour.
- ACTIVE_COLOR, 3'b010, lit pad colour.
- HOLD_CYCLES, 25000000, playback highlight duration in clocks (≥1).
- HOLD_W, 25, hold counter width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- begin_signal  in  1  start: initial draw of all pads.
- mode  in  1  0 = user input, 1 = playback.
- clicked  in  1  level, button pressed.
- direction  in  PAD_W  pad selected by user.
- pb_valid  in  1  playback request valid.
- pb_pad  in  PAD_W  playback pad index.
- pb_ready  out  1  accepts playback request.
- plot_valid  out  1  plot command valid.
- plot_ready  in  1  plotter accepts command.
- out_x  out  8  pad x coordinate.
- out_y  out  7  pad y coordinate.
- out_color  out  3  pad colour.
- busy  out  1  high in every state except START_WAIT and READY.
- pad_done  out  1  one-cycle pulse when a pad's restore plot is accepted.
- bad_pad  out  1  one-cycle pulse when a request index is ≥ N_PADS.

Behaviour:
- Reset (asynchronous, reset_n=0), all regardless of state:
  - state=START_WAIT.
  - out_x=0, out_y=0, out_color=0.
  - plot_valid=0, pb_ready=0, pad_done=0, bad_pad=0.
  - Hold counter=0, pad index=0, click edge register=0.
  - Mid-plot reset abandons the command with no completion.
- Click edge register: clicked_q is sampled every cycle. A click event is clicked=1 && clicked_q=0.
- States:
  - START_WAIT: on begin_signal=1 → INIT_DRAW with idx=0.
  - INIT_DRAW:
    - Drive plot_valid=1 with the idx coordinates and IDLE_COLOR.
    - On plot_ready: if idx==N_PADS-1 → READY, else idx+1.
  - READY:
    - Mode 0: on a click event, latch direction.
    - Mode 1: pb_ready=1; on pb_valid, latch pb_pad.
    - Latched index ≥ N_PADS: pulse bad_pad, stay in READY.
    - Otherwise → LIGHT.
    - Input from the non-selected mode is ignored.
  - LIGHT:
    - plot_valid=1 with the latched pad coordinates and ACTIVE_COLOR.
    - On plot_ready → HOLD; the counter loads HOLD_CYCLES-1.
  - HOLD:
    - Mode 0: leave when clicked=0.
    - Mode 1: leave when the counter reaches 0; the counter decrements each cycle.
    - → RESTORE.
    - mode is sampled at latch time and held for the whole operation.
  - RESTORE:
    - plot_valid=1 with the same pad coordinates and IDLE_COLOR.
    - On plot_ready: pulse pad_done → READY.
- Handshake rules:
  - out_x, out_y and out_color are registered and stay stable while plot_valid=1 && plot_ready=0.
  - plot_valid does not drop before acceptance.
  - A transfer happens on a clock edge where both plot_valid and plot_ready are 1.
  - plot_ready=1 held every cycle allows one transfer per cycle.
- Latency: a click event or pb handshake at edge t gives plot_valid=1 in the cycle after t (one register stage).
- pb_ready is combinational from the state register: 1 only in READY with mode=1. The pb handshake completes on the edge where pb_valid && pb_ready.
- begin_signal outside START_WAIT is ignored; there is no redraw-all while running.
- The table lookup uses the index bits only; the index is checked against N_PADS before the lookup.

Decomposition:
- Shared package simon_pkg:
  - State encoding localparams: START_WAIT, INIT_DRAW, READY, LIGHT, HOLD, RESTORE.
  - Default colour constants.
  - Default 4-pad coordinate tables.
  - The direction encoding, shared with the input decoder.
- One sub-module: pad_coord_lut. It is a combinational index → (x, y) slice of PAD_X_TABLE/PAD_Y_TABLE and reused by the plotter test patterns.

Test Plan (bench uses HOLD_CYCLES=4):
- Init draw: reset, begin_signal pulse, plot_ready=1 → exactly 4 plots in consecutive cycles with colour 7: (78,54), (78,62), (82,58), (74,58). Then busy=0.
- User press: mode=0, direction=2, clicked rises → plot (82,58,2) the next cycle. Hold clicked 10 cycles, then release → plot (82,58,7), pad_done pulse.
- Playback: mode=1, pb_valid with pb_pad=1 → pb_ready accepted, plot (78,62,2). Exactly 4 HOLD cycles, then plot (78,62,7).
- Backpressure: plot_ready=0 for 5 cycles during LIGHT → plot_valid and out_* remain constant. A single transfer occurs when plot_ready=1.
- Invalid/ignored inputs: N_PADS=3 build with direction=3 → bad_pad pulse, no plot. With mode=1, clicked is ignored. Holding clicked high produces no second event.
- Reset mid-HOLD: reset_n low asynchronously → all outputs 0 before the next edge. After release, START_WAIT ignores clicks until begin_signal.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon pad renderer and its neighbours.
// Holds the FSM state encoding, default colours, the default 4-pad coordinate
// tables, the direction encoding shared with the input decoder, and the
// plot command payload.
package simon_pkg;

    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned COLOR_W = 3;

    typedef enum logic [2:0] {
        START_WAIT = 3'd0,
        INIT_DRAW  = 3'd1,
        READY      = 3'd2,
        LIGHT      = 3'd3,
        HOLD       = 3'd4,
        RESTORE    = 3'd5
    } state_e;

    // Direction encoding used by the input decoder; doubles as the pad index.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam logic [COLOR_W-1:0] DEF_IDLE_COLOR   = 3'b111;
    localparam logic [COLOR_W-1:0] DEF_ACTIVE_COLOR = 3'b010;

    // Pad 0 occupies the least significant field.
    localparam logic [4*X_W-1:0] DEF_PAD_X_TABLE = {8'd74, 8'd82, 8'd78, 8'd78};
    localparam logic [4*Y_W-1:0] DEF_PAD_Y_TABLE = {7'd58, 7'd58, 7'd62, 7'd54};

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } plot_cmd_t;

endpackage

// File: rtl/simon_pad_renderer_if.sv
// Handshake bundle between the renderer, the playback source and the plotter.
//   pb_valid/pb_pad/pb_ready         : playback highlight requests
//   plot_valid/plot_ready/out_x/out_y/out_color : plot commands to the plotter
// master = renderer side, slave = surrounding logic / plotter side.
interface simon_pad_renderer_if
    import simon_pkg::*;
#(
    parameter int unsigned PAD_W = 2
);
    logic               pb_valid;
    logic [PAD_W-1:0]   pb_pad;
    logic               pb_ready;
    logic               plot_valid;
    logic               plot_ready;
    logic [X_W-1:0]     out_x;
    logic [Y_W-1:0]     out_y;
    logic [COLOR_W-1:0] out_color;

    modport master (
        input  pb_valid, pb_pad, plot_ready,
        output pb_ready, plot_valid, out_x, out_y, out_color
    );

    modport slave (
        output pb_valid, pb_pad, plot_ready,
        input  pb_ready, plot_valid, out_x, out_y, out_color
    );
endinterface

// File: rtl/pad_coord_lut.sv
// Combinational pad index -> screen coordinate lookup.
//   idx     : pad index (only values below N_PADS select a table entry)
//   pad_x_c : x coordinate of the pad, 0 for an index outside the table
//   pad_y_c : y coordinate of the pad, 0 for an index outside the table
module pad_coord_lut
    import simon_pkg::*;
#(
    parameter int unsigned             N_PADS      = 4,
    parameter int unsigned             PAD_W       = 2,
    parameter logic [N_PADS*X_W-1:0]   PAD_X_TABLE = (N_PADS*X_W)'(DEF_PAD_X_TABLE),
    parameter logic [N_PADS*Y_W-1:0]   PAD_Y_TABLE = (N_PADS*Y_W)'(DEF_PAD_Y_TABLE)
) (
    input  logic [PAD_W-1:0] idx,
    output logic [X_W-1:0]   pad_x_c,
    output logic [Y_W-1:0]   pad_y_c
);

    // Compare against each entry so an out-of-table index never slices past the table.
    always_comb begin
        pad_x_c = '0;
        pad_y_c = '0;
        for (int unsigned i = 0; i < N_PADS; i++) begin
            if (idx == PAD_W'(i)) begin
                pad_x_c = PAD_X_TABLE[i*X_W +: X_W];
                pad_y_c = PAD_Y_TABLE[i*Y_W +: Y_W];
            end
        end
    end

endmodule

// File: rtl/simon_pad_renderer.sv
// Simon pad renderer: draws N_PADS pads once on begin_signal, then lights one
// pad per request (player click or playback handshake), holds it, and
// restores it, issuing one plot command per pad update.
//   clock, reset_n      : clock, asynchronous active-low reset
//   begin_signal        : start the initial draw (only honoured in START_WAIT)
//   mode                : 0 = player input, 1 = playback
//   clicked, direction  : player button level and selected pad
//   busy                : high outside START_WAIT and READY
//   pad_done            : one-cycle pulse when a restore plot is accepted
//   bad_pad             : one-cycle pulse for a request index >= N_PADS
//   bus                 : playback request and plot command handshakes
module simon_pad_renderer
    import simon_pkg::*;
#(
    parameter int unsigned             N_PADS       = 4,
    parameter int unsigned             PAD_W        = 2,
    parameter logic [N_PADS*X_W-1:0]   PAD_X_TABLE  = (N_PADS*X_W)'(DEF_PAD_X_TABLE),
    parameter logic [N_PADS*Y_W-1:0]   PAD_Y_TABLE  = (N_PADS*Y_W)'(DEF_PAD_Y_TABLE),
    parameter logic [COLOR_W-1:0]      IDLE_COLOR   = DEF_IDLE_COLOR,
    parameter logic [COLOR_W-1:0]      ACTIVE_COLOR = DEF_ACTIVE_COLOR,
    parameter int unsigned             HOLD_CYCLES  = 25000000,
    parameter int unsigned             HOLD_W       = 25
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                begin_signal,
    input  logic                mode,
    input  logic                clicked,
    input  logic [PAD_W-1:0]    direction,
    output logic                busy,
    output logic                pad_done,
    output logic                bad_pad,
    simon_pad_renderer_if.master bus
);

    state_e             state_q, state_n;
    logic [PAD_W-1:0]   idx_q, idx_n;
    logic               mode_q, mode_n;
    logic [HOLD_W-1:0]  hold_q, hold_n;
    logic               clicked_q;
    logic               plot_valid_q, plot_valid_n;
    logic [COLOR_W-1:0] color_n;
    logic               pad_done_q, pad_done_n;
    logic               bad_pad_q, bad_pad_n;
    plot_cmd_t          cmd_q;

    logic               click_evt_c;
    logic               xfer_c;
    logic               req_c;
    logic [PAD_W-1:0]   req_idx_c;
    logic               req_ok_c;
    logic [X_W-1:0]     lut_x_c;
    logic [Y_W-1:0]     lut_y_c;

    assign click_evt_c = clicked & ~clicked_q;
    assign xfer_c      = plot_valid_q & bus.plot_ready;

    // Only the currently selected source can raise a request.
    assign req_idx_c   = mode ? bus.pb_pad : direction;
    assign req_c       = mode ? bus.pb_valid : click_evt_c;
    assign req_ok_c    = 32'(req_idx_c) < N_PADS;

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        mode_n       = mode_q;
        hold_n       = hold_q;
        plot_valid_n = plot_valid_q;
        color_n      = cmd_q.color;
        pad_done_n   = 1'b0;
        bad_pad_n    = 1'b0;

        unique case (state_q)
            START_WAIT: begin
                if (begin_signal) begin
                    state_n      = INIT_DRAW;
                    idx_n        = '0;
                    plot_valid_n = 1'b1;
                    color_n      = IDLE_COLOR;
                end
            end
            INIT_DRAW: begin
                if (xfer_c) begin
                    if (32'(idx_q) == N_PADS - 1) begin
                        state_n      = READY;
                        plot_valid_n = 1'b0;
                    end else begin
                        idx_n = idx_q + PAD_W'(1);
                    end
                end
            end
            READY: begin
                if (req_c) begin
                    if (req_ok_c) begin
                        state_n      = LIGHT;
                        idx_n        = req_idx_c;
                        mode_n       = mode;
                        plot_valid_n = 1'b1;
                        color_n      = ACTIVE_COLOR;
                    end else begin
                        bad_pad_n = 1'b1;
                    end
                end
            end
            LIGHT: begin
                if (xfer_c) begin
                    state_n      = HOLD;
                    plot_valid_n = 1'b0;
                    hold_n       = HOLD_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                // Player holds until release; playback holds for a fixed count.
                if (mode_q ? (hold_q == '0) : !clicked) begin
                    state_n      = RESTORE;
                    plot_valid_n = 1'b1;
                    color_n      = IDLE_COLOR;
                end else if (mode_q) begin
                    hold_n = hold_q - HOLD_W'(1);
                end
            end
            RESTORE: begin
                if (xfer_c) begin
                    state_n      = READY;
                    plot_valid_n = 1'b0;
                    pad_done_n   = 1'b1;
                end
            end
            default: state_n = START_WAIT;
        endcase
    end

    // Coordinates follow the next index so they land with plot_valid.
    pad_coord_lut #(
        .N_PADS      (N_PADS),
        .PAD_W       (PAD_W),
        .PAD_X_TABLE (PAD_X_TABLE),
        .PAD_Y_TABLE (PAD_Y_TABLE)
    ) u_lut (
        .idx     (idx_n),
        .pad_x_c (lut_x_c),
        .pad_y_c (lut_y_c)
    );

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= START_WAIT;
            idx_q        <= '0;
            mode_q       <= 1'b0;
            hold_q       <= '0;
            clicked_q    <= 1'b0;
            plot_valid_q <= 1'b0;
            pad_done_q   <= 1'b0;
            bad_pad_q    <= 1'b0;
            cmd_q        <= '0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            mode_q       <= mode_n;
            hold_q       <= hold_n;
            clicked_q    <= clicked;
            plot_valid_q <= plot_valid_n;
            pad_done_q   <= pad_done_n;
            bad_pad_q    <= bad_pad_n;
            // While stalled idx_n and color_n are unchanged, so the command stays stable.
            if (plot_valid_n) begin
                cmd_q <= '{x: lut_x_c, y: lut_y_c, color: color_n};
            end
        end
    end

    assign busy          = (state_q != START_WAIT) && (state_q != READY);
    assign bus.pb_ready  = (state_q == READY) && mode;
    assign bus.plot_valid = plot_valid_q;
    assign bus.out_x     = cmd_q.x;
    assign bus.out_y     = cmd_q.y;
    assign bus.out_color = cmd_q.color;
    assign pad_done      = pad_done_q;
    assign bad_pad       = bad_pad_q;

endmodule
